// File: rtl/rc_approx_add_arbiter.sv
// Two-requester round-robin front end sharing one ripple-carry adder whose low
// APPROX_BITS positions can switch to an approximate cell, with a one-entry result register.
module rc_approx_add_arbiter #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 12,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [WIDTH-1:0] req0_in2,
    input  logic             req0_approx,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [WIDTH-1:0] req1_in2,
    input  logic             req1_approx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_out,
    output logic             res_id,
    output logic [CNT_W-1:0] approx_cnt
);

    logic             res_valid_q, res_valid_d;
    logic [WIDTH:0]   res_out_q, res_out_d;
    logic             res_id_q, res_id_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic grant0, grant1, can_load, acc0, acc1;
    logic             sel_approx;
    logic [WIDTH-1:0] sel_in1, sel_in2;

    // Ripple chain: the approximate cell ignores the operand carry and always emits carry 1.
    function automatic logic [WIDTH:0] rc_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             approx
    );
        logic [WIDTH:0] s;
        logic           c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (approx && (i < APPROX_BITS)) begin
                s[i] = ~c & (~a[i] | b[i]);
                c    = 1'b1;
            end else begin
                s[i] = a[i] ^ b[i] ^ c;
                c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
        end
        s[WIDTH] = c;
        return s;
    endfunction

    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant_q);
        grant1     = req1_valid & (~req0_valid | ~last_grant_q);
        can_load   = ~res_valid_q | res_ready;
        req0_ready = grant0 & can_load & ~rst;
        req1_ready = grant1 & can_load & ~rst;
        acc0       = req0_valid & req0_ready;
        acc1       = req1_valid & req1_ready;

        sel_in1    = acc1 ? req1_in1 : req0_in1;
        sel_in2    = acc1 ? req1_in2 : req0_in2;
        sel_approx = acc1 ? req1_approx : req0_approx;

        res_valid_d  = res_valid_q;
        res_out_d    = res_out_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        if (acc0 || acc1) begin
            res_valid_d  = 1'b1;
            res_out_d    = rc_add(sel_in1, sel_in2, sel_approx);
            res_id_d     = acc1;
            last_grant_d = acc1;
            if (sel_approx && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_out_q    <= '0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_out_q    <= res_out_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_out    = res_out_q;
    assign res_id     = res_id_q;
    assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_rc_approx_add_arbiter.sv
// Directed bench for rc_approx_add_arbiter: arithmetic, round-robin, backpressure,
// mid-operation reset and counter saturation (counter narrowed to 4 bits).
module tb_rc_approx_add_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_approx;
    logic [15:0] req0_in1, req0_in2;
    logic        req1_valid, req1_ready, req1_approx;
    logic [15:0] req1_in1, req1_in2;
    logic        res_valid, res_ready, res_id;
    logic [16:0] res_out;
    logic [3:0]  approx_cnt;

    int errors = 0;
    int checks = 0;

    rc_approx_add_arbiter #(.WIDTH(16), .APPROX_BITS(12), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
        .req0_in2(req0_in2), .req0_approx(req0_approx),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
        .req1_in2(req1_in2), .req1_approx(req1_approx),
        .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
        .res_id(res_id), .approx_cnt(approx_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_approx = 1'b0;
        req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_approx = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", req1_ready); end
        tick(); tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        checks++; if (res_out !== 17'h0) begin errors++; $display("FAIL reset_out: got %h want 0", res_out); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %b want 0", res_id); end
        checks++; if (approx_cnt !== 4'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", approx_cnt); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_approx_req0();
        req0_valid = 1'b1; req0_in1 = 16'h1234; req0_in2 = 16'h0F0F; req0_approx = 1'b1;
        res_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL approx0_ready: got %b want 1", req0_ready); end
        tick();
        idle();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL approx0_valid: got %b want 1", res_valid); end
        checks++; if (res_out !== 17'h02001) begin errors++; $display("FAIL approx0_out: got %h want 02001", res_out); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL approx0_id: got %b want 0", res_id); end
        checks++; if (approx_cnt !== 4'h1) begin errors++; $display("FAIL approx0_cnt: got %h want 1", approx_cnt); end
    endtask

    task automatic test_exact_req1();
        req1_valid = 1'b1; req1_in1 = 16'h1234; req1_in2 = 16'h0F0F; req1_approx = 1'b0;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL exact1_ready: got %b want 1", req1_ready); end
        tick();
        checks++; if (res_out !== 17'h02143) begin errors++; $display("FAIL exact1_out: got %h want 02143", res_out); end
        checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL exact1_id: got %b want 1", res_id); end
        checks++; if (approx_cnt !== 4'h1) begin errors++; $display("FAIL exact1_cnt: got %h want 1", approx_cnt); end
        req1_in1 = 16'hFFFF; req1_in2 = 16'hFFFF; req1_approx = 1'b0;
        tick();
        checks++; if (res_out !== 17'h1FFFE) begin errors++; $display("FAIL exact_max_out: got %h want 1fffe", res_out); end
        req1_approx = 1'b1;
        tick();
        idle();
        checks++; if (res_out !== 17'h1F001) begin errors++; $display("FAIL approx_max_out: got %h want 1f001", res_out); end
        checks++; if (approx_cnt !== 4'h2) begin errors++; $display("FAIL approx_max_cnt: got %h want 2", approx_cnt); end
    endtask

    task automatic test_round_robin();
        logic       exp_id;
        logic [16:0] exp_out;
        req0_valid = 1'b1; req0_in1 = 16'h0001; req0_in2 = 16'h0001; req0_approx = 1'b0;
        req1_valid = 1'b1; req1_in1 = 16'h0002; req1_in2 = 16'h0002; req1_approx = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id  = (i % 2 == 1);
            exp_out = exp_id ? 17'h00004 : 17'h00002;
            #1;
            checks++; if (req0_ready !== ~exp_id) begin errors++; $display("FAIL rr_ready0[%0d]: got %b want %b", i, req0_ready, ~exp_id); end
            checks++; if (req1_ready !== exp_id) begin errors++; $display("FAIL rr_ready1[%0d]: got %b want %b", i, req1_ready, exp_id); end
            tick();
            checks++; if (res_id !== exp_id) begin errors++; $display("FAIL rr_id[%0d]: got %b want %b", i, res_id, exp_id); end
            checks++; if (res_out !== exp_out) begin errors++; $display("FAIL rr_out[%0d]: got %h want %h", i, res_out, exp_out); end
        end
        idle();
    endtask

    task automatic test_backpressure();
        // Held result from the round-robin run: requester 1, value 4.
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_in1 = 16'h0010; req0_in2 = 16'h0020;
        req1_valid = 1'b1; req1_in1 = 16'h0100; req1_in2 = 16'h0200;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {req0_ready, req1_ready}); end
            tick();
            checks++; if (res_out !== 17'h00004) begin errors++; $display("FAIL bp_out[%0d]: got %h want 00004", i, res_out); end
            checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, res_valid); end
        end
        req0_valid = 1'b0;
        res_ready = 1'b1;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready1: got %b want 1", req1_ready); end
        tick();
        idle();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_swap_valid: got %b want 1", res_valid); end
        checks++; if (res_out !== 17'h00300) begin errors++; $display("FAIL bp_swap_out: got %h want 00300", res_out); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid: got %b want 0", res_valid); end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_in1 = 16'h0000; req0_in2 = 16'h0000; req0_approx = 1'b1;
        res_ready = 1'b1;
        tick(); tick(); tick();
        idle();
        res_ready = 1'b0;
        checks++; if (res_out !== 17'h01001) begin errors++; $display("FAIL mid_out: got %h want 01001", res_out); end
        checks++; if (approx_cnt !== 4'h5) begin errors++; $display("FAIL mid_cnt: got %h want 5", approx_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", res_valid); end
        checks++; if (approx_cnt !== 4'h0) begin errors++; $display("FAIL mid_rst_cnt: got %h want 0", approx_cnt); end
        checks++; if (res_out !== 17'h0) begin errors++; $display("FAIL mid_rst_out: got %h want 0", res_out); end
        req0_valid = 1'b1; req0_in1 = 16'h0003; req0_in2 = 16'h0004;
        req1_valid = 1'b1; req1_in1 = 16'h0005; req1_in2 = 16'h0006;
        res_ready = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL mid_grant: got %b want 10", {req0_ready, req1_ready}); end
        tick();
        idle();
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL mid_id: got %b want 0", res_id); end
        checks++; if (res_out !== 17'h00007) begin errors++; $display("FAIL mid_sum: got %h want 00007", res_out); end
    endtask

    task automatic test_saturation();
        req0_valid = 1'b1; req0_in1 = 16'h00FF; req0_in2 = 16'h0F00; req0_approx = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i == 13) begin
                checks++; if (approx_cnt !== 4'hE) begin errors++; $display("FAIL sat_cnt14: got %h want e", approx_cnt); end
            end
        end
        idle();
        checks++; if (approx_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt17: got %h want f", approx_cnt); end
        // bit0 = ~1|0 = 0; hi = 0x0 + 0x0 + 1.
        checks++; if (res_out !== 17'h01000) begin errors++; $display("FAIL sat_out: got %h want 01000", res_out); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        res_ready = 1'b1;
        test_reset();
        test_approx_req0();
        test_exact_req1();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
